// File: rtl/efi_pkg.sv
// Shared ignition types and default timing constants.
// Imported by the sequencer, its channels and its interface.
package efi_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_DWELL   = 2'd1,
    CH_HOLDOFF = 2'd2
  } ch_state_e;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_PW            = 16;
  localparam int DEF_MAX_DWELL_CYC = 16000;
  localparam int DEF_MIN_OFF_CYC   = 200;

endpackage

// File: rtl/ign_sequencer_if.sv
// Signal bundle between an engine-position master and ign_sequencer.
// master drives position/config, slave returns coil and status.
interface ign_sequencer_if
  import efi_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int PW   = DEF_PW
);

  logic                 synced;
  logic [PW-1:0]        eng_phase;
  logic [PW-1:0]        qpr;
  logic [N_CH*PW-1:0]   ch_phase;
  logic [PW-1:0]        timing;
  logic [PW-1:0]        dwell;
  logic [N_CH-1:0]      en;
  logic [N_CH-1:0]      cut_mask;
  logic                 dist_mode;
  logic                 fault_clr;
  logic [N_CH-1:0]      ign;
  logic [N_CH-1:0]      fault;
  logic                 cfg_err;

  modport master (
    output synced, eng_phase, qpr,
    output ch_phase, timing, dwell,
    output en, cut_mask, dist_mode,
    output fault_clr,
    input  ign, fault, cfg_err
  );

  modport slave (
    input  synced, eng_phase, qpr,
    input  ch_phase, timing, dwell,
    input  en, cut_mask, dist_mode,
    input  fault_clr,
    output ign, fault, cfg_err
  );

endinterface

// File: rtl/ign_channel.sv
// One coil: dwell window decode, IDLE/DWELL/HOLDOFF FSM and counters.
// dwell_nxt is the next-cycle coil state, registered by the parent.
module ign_channel
  import efi_pkg::*;
#(
  parameter int PW            = DEF_PW,
  parameter int MAX_DWELL_CYC = DEF_MAX_DWELL_CYC,
  parameter int MIN_OFF_CYC   = DEF_MIN_OFF_CYC
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          synced,
  input  logic          cfg_ok,
  input  logic [PW-1:0] eng_phase,
  input  logic [PW-1:0] prev_phase,
  input  logic [PW-1:0] qpr,
  input  logic [PW-1:0] ch_phase,
  input  logic [PW-1:0] timing,
  input  logic [PW-1:0] dwell,
  input  logic          en,
  input  logic          cut,
  output logic          dwell_nxt,
  output logic          timeout
);

  localparam int DW = $clog2(MAX_DWELL_CYC + 2);
  localparam int HW = $clog2(MIN_OFF_CYC + 2);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DWELL_CYC);
  localparam logic [HW-1:0] HMAX = HW'(MIN_OFF_CYC);

  logic [PW:0]   d_fire;
  logic [PW:0]   d_start;
  logic [PW-1:0] fire;
  logic [PW-1:0] start;
  logic          win_now;
  logic          win_prev;
  logic          entry;

  ch_state_e     state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  function automatic logic in_win(
    input logic [PW-1:0] ph,
    input logic [PW-1:0] s,
    input logic [PW-1:0] f,
    input logic [PW-1:0] dw
  );
    if (dw == '0) return 1'b0;
    if (s <= f) return (ph >= s) && (ph < f);
    return (ph >= s) || (ph < f);
  endfunction

  assign d_fire  = {1'b0, ch_phase} - {1'b0, timing};
  assign fire    = d_fire[PW] ? d_fire[PW-1:0] + qpr
                              : d_fire[PW-1:0];
  assign d_start = {1'b0, fire} - {1'b0, dwell};
  assign start   = d_start[PW] ? d_start[PW-1:0] + qpr
                               : d_start[PW-1:0];

  // Entry compares against the previous phase under the same
  // window, so a fresh load inside the window is not an entry.
  assign win_now  = in_win(eng_phase, start, fire, dwell);
  assign win_prev = in_win(prev_phase, start, fire, dwell);
  assign entry    = win_now && !win_prev;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    timeout = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (en && !cut && entry) begin
          state_d = CH_DWELL;
          dcnt_d  = '0;
        end
      end
      CH_DWELL: begin
        dcnt_d = (dcnt_q == DMAX) ? dcnt_q
                                  : dcnt_q + DW'(1);
        if (dcnt_d == DMAX) begin
          timeout = 1'b1;
          state_d = CH_HOLDOFF;
          hcnt_d  = '0;
        end else if (!win_now) begin
          state_d = CH_HOLDOFF;
          hcnt_d  = '0;
        end
      end
      CH_HOLDOFF: begin
        hcnt_d = (hcnt_q == HMAX) ? hcnt_q
                                  : hcnt_q + HW'(1);
        if (hcnt_d >= HMAX) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
    if (!synced || !cfg_ok) begin
      state_d = CH_IDLE;
      dcnt_d  = '0;
      hcnt_d  = '0;
      timeout = 1'b0;
    end
  end

  assign dwell_nxt = (state_d == CH_DWELL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

endmodule

// File: rtl/ign_sequencer.sv
// Multi-channel ignition sequencer: per-revolution shadow config,
// wrap detect, config check, fault latch and distributor muxing.
module ign_sequencer
  import efi_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int PW            = DEF_PW,
  parameter int MAX_DWELL_CYC = DEF_MAX_DWELL_CYC,
  parameter int MIN_OFF_CYC   = DEF_MIN_OFF_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               synced,
  input  logic [PW-1:0]      eng_phase,
  input  logic [PW-1:0]      qpr,
  input  logic [N_CH*PW-1:0] ch_phase,
  input  logic [PW-1:0]      timing,
  input  logic [PW-1:0]      dwell,
  input  logic [N_CH-1:0]    en,
  input  logic [N_CH-1:0]    cut_mask,
  input  logic               dist_mode,
  input  logic               fault_clr,
  output logic [N_CH-1:0]    ign,
  output logic [N_CH-1:0]    fault,
  output logic               cfg_err
);

  logic [PW-1:0]      prev_q, prev_d;
  logic               synced_q, synced_d;
  logic [PW-1:0]      qpr_q, qpr_d;
  logic [N_CH*PW-1:0] chph_q, chph_d;
  logic [PW-1:0]      timing_q, timing_d;
  logic [PW-1:0]      dwell_q, dwell_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic [N_CH-1:0]    cut_q, cut_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [N_CH-1:0]    ign_q, ign_d;
  logic [N_CH-1:0]    fault_q, fault_d;

  logic [N_CH-1:0]    dw;
  logic [N_CH-1:0]    to;
  logic               wrap;
  logic               load;
  logic               bad;

  assign wrap = synced && (eng_phase < prev_q);
  assign load = wrap || (synced && !synced_q);

  always_comb begin
    bad = (qpr == '0) || (timing >= qpr) || (dwell >= qpr);
    for (int i = 0; i < N_CH; i++) begin
      if (ch_phase[i*PW +: PW] >= qpr) bad = 1'b1;
    end
  end

  // ok_q gates firing until a valid load after reset.
  always_comb begin
    prev_d   = eng_phase;
    synced_d = synced;
    qpr_d    = qpr_q;
    chph_d   = chph_q;
    timing_d = timing_q;
    dwell_d  = dwell_q;
    en_d     = en_q;
    cut_d    = cut_q;
    ok_d     = ok_q;
    err_d    = err_q;
    if (load) begin
      qpr_d    = qpr;
      chph_d   = ch_phase;
      timing_d = timing;
      dwell_d  = dwell;
      en_d     = en;
      cut_d    = cut_mask;
      ok_d     = !bad;
      err_d    = bad;
    end
    ign_d = dw;
    if (dist_mode) begin
      ign_d    = '0;
      ign_d[0] = |dw;
    end
    fault_d = (fault_q & ~{N_CH{fault_clr}}) | to;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      synced_q <= 1'b0;
      qpr_q    <= '0;
      chph_q   <= '0;
      timing_q <= '0;
      dwell_q  <= '0;
      en_q     <= '0;
      cut_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ign_q    <= '0;
      fault_q  <= '0;
    end else begin
      prev_q   <= prev_d;
      synced_q <= synced_d;
      qpr_q    <= qpr_d;
      chph_q   <= chph_d;
      timing_q <= timing_d;
      dwell_q  <= dwell_d;
      en_q     <= en_d;
      cut_q    <= cut_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ign_q    <= ign_d;
      fault_q  <= fault_d;
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ign_channel #(
        .PW            (PW),
        .MAX_DWELL_CYC (MAX_DWELL_CYC),
        .MIN_OFF_CYC   (MIN_OFF_CYC)
      ) u_ch (
        .clk        (clk),
        .reset_n    (reset_n),
        .synced     (synced),
        .cfg_ok     (ok_q),
        .eng_phase  (eng_phase),
        .prev_phase (prev_q),
        .qpr        (qpr_q),
        .ch_phase   (chph_q[g*PW +: PW]),
        .timing     (timing_q),
        .dwell      (dwell_q),
        .en         (en_q[g]),
        .cut        (cut_q[g]),
        .dwell_nxt  (dw[g]),
        .timeout    (to[g])
      );
    end
  endgenerate

  assign ign     = ign_q;
  assign fault   = fault_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_ign_sequencer.sv
// Directed bench for ign_sequencer: steps crank phase one
// quantum per clock and checks coil, fault and cfg_err.
module tb_ign_sequencer;

  localparam int N   = 4;
  localparam int PW  = 16;
  localparam int QPR = 6144;

  logic clk = 1'b0;
  logic reset_n;

  int ncmp = 0;
  int nerr = 0;
  int rises[N];
  int hi[N];
  logic [N-1:0] prev_ign;

  ign_sequencer_if #(.N_CH(N), .PW(PW)) bus ();

  ign_sequencer #(
    .N_CH          (N),
    .PW            (PW),
    .MAX_DWELL_CYC (16000),
    .MIN_OFF_CYC   (200)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .synced    (bus.synced),
    .eng_phase (bus.eng_phase),
    .qpr       (bus.qpr),
    .ch_phase  (bus.ch_phase),
    .timing    (bus.timing),
    .dwell     (bus.dwell),
    .en        (bus.en),
    .cut_mask  (bus.cut_mask),
    .dist_mode (bus.dist_mode),
    .fault_clr (bus.fault_clr),
    .ign       (bus.ign),
    .fault     (bus.fault),
    .cfg_err   (bus.cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.ign[i] && !prev_ign[i]) rises[i]++;
      if (bus.ign[i]) hi[i]++;
    end
    prev_ign = bus.ign;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      if (bus.eng_phase == 16'(QPR - 1))
        bus.eng_phase = '0;
      else
        bus.eng_phase = bus.eng_phase + 16'd1;
      tick();
    end
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      rises[i] = 0;
      hi[i]    = 0;
    end
    prev_ign = bus.ign;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.synced    = 1'b0;
    bus.eng_phase = '0;
    bus.qpr       = 16'd6144;
    bus.ch_phase  = {16'd4608, 16'd3072, 16'd1536, 16'd0};
    bus.timing    = '0;
    bus.dwell     = 16'd512;
    bus.en        = 4'b1111;
    bus.cut_mask  = '0;
    bus.dist_mode = 1'b0;
    bus.fault_clr = 1'b0;
    prev_ign      = '0;
    clear();
    tick();
    tick();
    check("rst_ign", 32'(bus.ign), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);

    // Normal dwell: window 5632..6143 for channel 0
    reset_n = 1'b1;
    tick();
    bus.synced = 1'b1;
    tick();
    check("a_load_cfg_err", 32'(bus.cfg_err), 0);
    clear();
    advance(5631);
    check("a_pre_5632", 32'(bus.ign[0]), 0);
    advance(1);
    check("a_rise_5632", 32'(bus.ign[0]), 1);
    advance(511);
    check("a_hold_6143", 32'(bus.ign[0]), 1);
    check("a_width", 32'(hi[0]), 512);
    advance(1);
    check("a_fall_0", 32'(bus.ign[0]), 0);
    check("a_rises_123",
          32'(100 * rises[1] + 10 * rises[2] + rises[3]), 111);
    check("a_no_fault", 32'(bus.fault), 0);

    // Dwell timeout with phase frozen inside the window
    advance(5632);
    check("b_rise", 32'(bus.ign[0]), 1);
    bus.eng_phase = 16'd5700;
    repeat (15999) tick();
    check("b_still_dwell", 32'(bus.ign[0]), 1);
    check("b_no_fault_yet", 32'(bus.fault), 0);
    tick();
    check("b_timeout_fall", 32'(bus.ign[0]), 0);
    check("b_fault_set", 32'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    check("b_fault_clr", 32'(bus.fault), 0);
    clear();
    advance(444);
    check("b_no_reentry", 32'(hi[0]), 0);

    // Cut applied mid-revolution takes effect one wrap later
    clear();
    advance(3000);
    bus.cut_mask = 4'b0001;
    advance(3144);
    check("c_cur_rev_ch0", 32'(rises[0]), 1);
    check("c_cur_rev_oth",
          32'(100 * rises[1] + 10 * rises[2] + rises[3]), 111);
    clear();
    bus.cut_mask = '0;
    advance(6144);
    check("c_next_rev_ch0", 32'(rises[0]), 0);
    check("c_next_rev_oth",
          32'(100 * rises[1] + 10 * rises[2] + rises[3]), 111);

    // Distributor mode, channels at 0/2048/4096
    bus.dist_mode = 1'b1;
    bus.ch_phase  = {16'd4608, 16'd4096, 16'd2048, 16'd0};
    bus.en        = 4'b0111;
    advance(6144);
    clear();
    advance(6144);
    check("d_pulses", 32'(rises[0]), 3);
    check("d_width", 32'(hi[0]), 1536);
    check("d_upper_zero", 32'(hi[1] + hi[2] + hi[3]), 0);

    // Invalid dwell latched at the wrap
    bus.dist_mode = 1'b0;
    bus.dwell     = 16'd7000;
    advance(6144);
    check("e_cfg_err", 32'(bus.cfg_err), 1);
    check("e_ign_zero", 32'(bus.ign), 0);
    clear();
    advance(2000);
    check("e_no_dwell", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 0);
    bus.dwell  = 16'd512;
    bus.synced = 1'b0;
    tick();
    bus.synced = 1'b1;
    tick();
    check("e_cfg_err_clr", 32'(bus.cfg_err), 0);

    // Enable inside the window, then reset during dwell
    bus.synced    = 1'b0;
    bus.eng_phase = 16'd5800;
    bus.ch_phase  = {16'd4608, 16'd3072, 16'd1536, 16'd0};
    bus.en        = 4'b0000;
    tick();
    bus.en = 4'b0001;
    tick();
    bus.synced = 1'b1;
    tick();
    clear();
    advance(343);
    check("f_midwin_no_dwell", 32'(hi[0]), 0);
    advance(1);
    advance(5700);
    check("f_dwell", 32'(bus.ign[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("f_rst_ign", 32'(bus.ign), 0);
    check("f_rst_fault", 32'(bus.fault), 0);
    tick();
    reset_n = 1'b1;
    clear();
    advance(400);
    check("f_no_fire_after_rst", 32'(hi[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ign_sequencer.md
IGN_SEQUENCER -- requirements
Module: ign_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of ignition channels (1..8).
REQ-002 SHALL have parameter PW, default 16, meaning the width of every phase, quanta and dwell value.
REQ-003 SHALL have parameter MAX_DWELL_CYC, default 16000, meaning the dwell timeout in clk cycles.
REQ-004 SHALL have parameter MIN_OFF_CYC, default 200, meaning the post-fire holdoff in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port synced, input, 1 bit: the engine position is valid.
REQ-008 SHALL have port eng_phase, input, PW bits: current crank phase in quanta, 0..qpr-1.
REQ-009 SHALL have port qpr, input, PW bits: quanta per revolution.
REQ-010 SHALL have port ch_phase, input, N_CH*PW bits: per-channel TDC offset, in quanta.
REQ-011 SHALL have port timing, input, PW bits: advance in quanta before each channel's TDC.
REQ-012 SHALL have port dwell, input, PW bits: dwell angle in quanta.
REQ-013 SHALL have port en, input, N_CH bits: per-channel enable.
REQ-014 SHALL have port cut_mask, input, N_CH bits: when 1, the channel is skipped for the next revolution.
REQ-015 SHALL have port dist_mode, input, 1 bit: when 1, all channels are ORed onto ign[0].
REQ-016 SHALL have port fault_clr, input, 1 bit: clears fault.
REQ-017 SHALL have port ign, output, N_CH bits: coil drive, high during dwell.
REQ-018 SHALL have port fault, output, N_CH bits: sticky dwell-timeout flag.
REQ-019 SHALL have port cfg_err, output, 1 bit: the shadow configuration is invalid.

Function
REQ-020 SHALL treat a cycle where synced=1 and eng_phase < the previous registered eng_phase as a wrap.
REQ-021 SHALL copy qpr, ch_phase, timing, dwell, en and cut_mask into shadow registers on each wrap, and also on the first cycle after synced rises.
REQ-022 SHALL otherwise leave the shadow registers unchanged, so mid-revolution input changes have no effect.
REQ-023 SHALL compute, per channel, fire = (ch_phase - timing) mod qpr and start = (fire - dwell) mod qpr, using conditional add-qpr on underflow with PW+1-bit intermediates.
REQ-024 SHALL define the dwell window as start <= eng_phase < fire when start <= fire, and as eng_phase >= start OR eng_phase < fire otherwise.
REQ-025 SHALL set cfg_err=1 and force all channels idle while any shadow ch_phase, timing or dwell is >= qpr, or qpr = 0; cfg_err SHALL clear at the next valid load.
REQ-026 SHALL treat dwell = 0 as an empty window, so the channel never fires.
REQ-027 SHALL implement a per-channel FSM with states IDLE, DWELL and HOLDOFF.
REQ-028 SHALL move IDLE->DWELL only on window entry (in-window now, out-of-window on the previous cycle) with synced, en=1 and cut=0; starting mid-window SHALL NOT dwell.
REQ-029 SHALL move DWELL->HOLDOFF on window exit (the spark), or when the dwell counter reaches MAX_DWELL_CYC, which also sets fault[ch].
REQ-030 SHALL move DWELL->IDLE with no fault if synced drops.
REQ-031 SHALL move HOLDOFF->IDLE after MIN_OFF_CYC cycles; window entries during HOLDOFF SHALL be ignored.
REQ-032 SHALL register ign, so ign[ch]=1 exactly in DWELL, with 1 cycle latency from the eng_phase sample.
REQ-033 SHALL, when dist_mode=1, drive ign[0] as the OR of all internal channels and drive ign[N_CH-1:1] to 0.
REQ-034 SHALL clear fault on fault_clr; if a fault is set in the same cycle, set wins.
REQ-035 SHALL saturate the dwell counter at MAX_DWELL_CYC and the holdoff counter at MIN_OFF_CYC.

Reset
REQ-036 SHALL, on reset_n=0, asynchronously force all FSMs to IDLE and drive ign=0, fault=0, cfg_err=0 and the counters to 0.
REQ-037 SHALL also clear the shadow registers and the previous-phase register on reset_n=0.
REQ-038 SHALL, on reset mid-dwell, drop ign to 0 immediately without setting fault.
REQ-039 SHALL require a fresh wrap or synced rise before any channel fires after reset.

Structure
REQ-040 SHALL place the FSM state encoding and the default parameter constants in shared package efi_pkg.
REQ-041 SHALL place the per-channel FSM, window logic and counters in sub-module ign_channel, instantiated N_CH times via generate.
REQ-042 SHALL keep the shadow registers, wrap detection, cfg_err and dist_mode muxing in the top-level module.

Verification
REQ-043 SHALL verify normal dwell: qpr=6144, ch_phase[0]=0, timing=0, dwell=512, sweep eng_phase by 1 per cycle -> ign[0] rises 1 cycle after phase 5632 and falls 1 cycle after phase 0.
REQ-044 SHALL verify dwell timeout: same configuration, hold eng_phase at 5700 -> ign[0] falls after 16000 cycles, fault[0]=1, and fault_clr clears it.
REQ-045 SHALL verify cut and shadowing: cut_mask=0001 asserted mid-revolution -> the current revolution still fires, the next revolution skips channel 0, and other channels are unaffected.
REQ-046 SHALL verify distributor mode: dist_mode=1 with phases 0/2048/4096 -> ign[0] pulses three times per revolution and ign[3:1]=0.
REQ-047 SHALL verify invalid configuration: dwell=7000 with qpr=6144 -> after the wrap cfg_err=1 and ign=0.
REQ-048 SHALL verify mid-window start and reset: enable the channel while eng_phase is inside the window -> no dwell that revolution; reset_n pulsed during DWELL -> ign=0 asynchronously with fault=0.
